// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared writeback-select and load funct3 encodings
package core_pkg;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_IMM = 2'd3
  } wb_sel_t;

  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;

  // True for the five load encodings the core implements.
  function automatic logic is_legal_load(input logic [2:0] funct3);
    return (funct3 == LD_LB) || (funct3 == LD_LH) || (funct3 == LD_LW) ||
           (funct3 == LD_LBU) || (funct3 == LD_LHU);
  endfunction

endpackage

// File: rtl/wb_stage_if.sv
// rtl/wb_stage_if.sv - MEM-to-WB inputs and register-file write port bundle
interface wb_stage_if #(
  parameter int XLEN = 32
);

  logic            en;
  logic            flush;
  logic            valid_in;
  logic            reg_write_in;
  logic [4:0]      rd_in;
  logic [1:0]      wb_sel_in;
  logic [2:0]      load_type_in;
  logic [1:0]      addr_low_in;
  logic [XLEN-1:0] alu_in;
  logic [XLEN-1:0] mem_rdata_in;
  logic [XLEN-1:0] pc4_in;
  logic [XLEN-1:0] imm_in;

  logic [4:0]      Wt_addr;
  logic [XLEN-1:0] Wt_data;
  logic            L_S;
  logic            valid_out;
  logic            fwd_en;
  logic            load_err;
  logic [XLEN-1:0] pc4_out;

  // Upstream pipeline side: drives MEM results, observes the write port.
  modport master (
    output en, flush, valid_in, reg_write_in, rd_in, wb_sel_in,
           load_type_in, addr_low_in, alu_in, mem_rdata_in, pc4_in, imm_in,
    input  Wt_addr, Wt_data, L_S, valid_out, fwd_en, load_err, pc4_out
  );

  // The WB stage itself.
  modport slave (
    input  en, flush, valid_in, reg_write_in, rd_in, wb_sel_in,
           load_type_in, addr_low_in, alu_in, mem_rdata_in, pc4_in, imm_in,
    output Wt_addr, Wt_data, L_S, valid_out, fwd_en, load_err, pc4_out
  );

endinterface

// File: rtl/wb_stage_load_align.sv
// rtl/wb_stage_load_align.sv - little-endian load extraction and misalign detect
module load_align
  import core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] raw_word,
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  output logic [XLEN-1:0] data,
  output logic            misalign
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  assign sel_byte = raw_word[{offset, 3'b000} +: 8];
  assign sel_half = raw_word[{offset[1], 4'b0000} +: 16];

  // Select and extend the addressed lane; flag odd halfwords, unaligned words
  // and funct3 values that are not loads.
  always_comb begin
    data     = '0;
    misalign = 1'b0;
    unique case (funct3)
      LD_LB:  data = {{(XLEN-8){sel_byte[7]}}, sel_byte};
      LD_LBU: data = {{(XLEN-8){1'b0}}, sel_byte};
      LD_LH: begin
        data     = {{(XLEN-16){sel_half[15]}}, sel_half};
        misalign = offset[0];
      end
      LD_LHU: begin
        data     = {{(XLEN-16){1'b0}}, sel_half};
        misalign = offset[0];
      end
      LD_LW: begin
        data     = raw_word;
        misalign = (offset != 2'b00);
      end
      default: misalign = 1'b1;
    endcase
    if (!is_legal_load(funct3)) begin
      misalign = 1'b1;
    end
  end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - MEM/WB pipeline register with writeback select and load alignment
module wb_stage
  import core_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC4 = 32'h0000_0004
) (
  input  logic      clk,
  input  logic      rst,
  wb_stage_if.slave bus
);

  logic            q_valid;
  logic            q_reg_write;
  logic [4:0]      q_rd;
  wb_sel_t         q_wb_sel;
  logic [2:0]      q_load_type;
  logic [1:0]      q_addr_low;
  logic [XLEN-1:0] q_alu;
  logic [XLEN-1:0] q_mem_rdata;
  logic [XLEN-1:0] q_pc4;
  logic [XLEN-1:0] q_imm;

  logic [XLEN-1:0] load_data;
  logic            load_misalign;
  logic            load_fault;
  logic [XLEN-1:0] sel_data;

  // Pipeline register: reset, then flush (bubble, overrides stall), then capture or hold.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      q_valid     <= 1'b0;
      q_reg_write <= 1'b0;
      q_rd        <= '0;
      q_wb_sel    <= WB_ALU;
      q_load_type <= '0;
      q_addr_low  <= '0;
      q_alu       <= '0;
      q_mem_rdata <= '0;
      q_pc4       <= RESET_PC4;
      q_imm       <= '0;
    end else if (bus.en) begin
      q_valid     <= bus.valid_in;
      q_reg_write <= bus.reg_write_in;
      q_rd        <= bus.rd_in;
      q_wb_sel    <= wb_sel_t'(bus.wb_sel_in);
      q_load_type <= bus.load_type_in;
      q_addr_low  <= bus.addr_low_in;
      q_alu       <= bus.alu_in;
      q_mem_rdata <= bus.mem_rdata_in;
      q_pc4       <= bus.pc4_in;
      q_imm       <= bus.imm_in;
    end
  end

  // Alignment works on registered fields so the stage has no input-to-output path.
  load_align #(
    .XLEN(XLEN)
  ) u_load_align (
    .raw_word (q_mem_rdata),
    .funct3   (q_load_type),
    .offset   (q_addr_low),
    .data     (load_data),
    .misalign (load_misalign)
  );

  assign load_fault = (q_wb_sel == WB_MEM) && load_misalign;

  // Writeback source select; a faulting load presents zero data.
  always_comb begin
    sel_data = '0;
    unique case (q_wb_sel)
      WB_ALU:  sel_data = q_alu;
      WB_MEM:  sel_data = load_data;
      WB_PC4:  sel_data = q_pc4;
      WB_IMM:  sel_data = q_imm;
      default: sel_data = '0;
    endcase
    if (load_fault) begin
      sel_data = '0;
    end
  end

  // x0 writes still reach the register file, but never act as a forwarding source.
  assign bus.Wt_addr   = q_rd;
  assign bus.Wt_data   = sel_data;
  assign bus.L_S       = q_valid & q_reg_write & ~load_fault;
  assign bus.valid_out = q_valid;
  assign bus.fwd_en    = bus.L_S & (q_rd != 5'd0);
  assign bus.load_err  = q_valid & load_fault;
  assign bus.pc4_out   = q_pc4;

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - randomized self-checking bench for wb_stage
module tb_wb_stage;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  wb_stage_if #(.XLEN(32)) bus ();

  wb_stage #(
    .XLEN      (32),
    .RESET_PC4 (32'h0000_0004)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model: contents of the WB slot as an architectural record.
  bit          m_valid, m_rw;
  int unsigned m_rd, m_sel, m_f3, m_off;
  bit [31:0]   m_alu, m_rdata, m_pc4, m_imm;

  bit [4:0]  e_addr;
  bit [31:0] e_data, e_pc4;
  bit        e_ls, e_valid, e_fwd, e_err;

  function automatic void ref_load(input bit [31:0] w, input int unsigned f3,
                                   input int unsigned off, output bit bad,
                                   output bit [31:0] d);
    int unsigned b, h;
    b   = (w >> (8 * off)) % 256;
    h   = (w >> (8 * (off / 2) * 2)) % 65536;
    bad = 1'b0;
    d   = 32'd0;
    if (f3 == 0)      d = (b >= 128) ? b - 256 : b;
    else if (f3 == 4) d = b;
    else if (f3 == 1) begin d = (h >= 32768) ? h - 65536 : h; bad = (off % 2) != 0; end
    else if (f3 == 5) begin d = h; bad = (off % 2) != 0; end
    else if (f3 == 2) begin d = w; bad = off != 0; end
    else bad = 1'b1;
  endfunction

  function automatic void compute_expected();
    bit        bad;
    bit [31:0] ld;
    ref_load(m_rdata, m_f3, m_off, bad, ld);
    bad     = bad && (m_sel == 1);
    e_addr  = m_rd[4:0];
    e_valid = m_valid;
    e_pc4   = m_pc4;
    e_err   = m_valid && bad;
    e_ls    = m_valid && m_rw && !bad;
    e_fwd   = e_ls && (m_rd != 0);
    if (bad)            e_data = 32'd0;
    else if (m_sel == 0) e_data = m_alu;
    else if (m_sel == 1) e_data = ld;
    else if (m_sel == 2) e_data = m_pc4;
    else                 e_data = m_imm;
  endfunction

  task automatic tick();
    if (rst || bus.flush) begin
      m_valid = 0; m_rw = 0; m_rd = 0; m_sel = 0; m_f3 = 0; m_off = 0;
      m_alu = 0; m_rdata = 0; m_pc4 = 32'h4; m_imm = 0;
    end else if (bus.en) begin
      m_valid = bus.valid_in; m_rw = bus.reg_write_in; m_rd = bus.rd_in;
      m_sel = bus.wb_sel_in; m_f3 = bus.load_type_in; m_off = bus.addr_low_in;
      m_alu = bus.alu_in; m_rdata = bus.mem_rdata_in; m_pc4 = bus.pc4_in;
      m_imm = bus.imm_in;
    end
    @(posedge clk);
    #1;
    compute_expected();
  endtask

  task automatic random_inputs();
    bus.valid_in     = 1'($urandom);
    bus.reg_write_in = 1'($urandom);
    bus.rd_in        = 5'($urandom);
    bus.wb_sel_in    = 2'($urandom);
    bus.load_type_in = 3'($urandom);
    bus.addr_low_in  = 2'($urandom);
    bus.alu_in       = $urandom;
    bus.mem_rdata_in = $urandom;
    bus.pc4_in       = $urandom;
    bus.imm_in       = $urandom;
  endtask

  task automatic set_op(input int rd, input int sel, input int f3, input int off);
    bus.valid_in = 1; bus.reg_write_in = 1; bus.rd_in = 5'(rd);
    bus.wb_sel_in = 2'(sel); bus.load_type_in = 3'(f3); bus.addr_low_in = 2'(off);
  endtask

  task automatic test_reset();
    rst = 1; bus.en = 1'($urandom); bus.flush = 1'($urandom);
    for (int i = 0; i < 2; i++) begin
      random_inputs();
      tick();
      n_tests++;
      if (bus.L_S !== 1'b0) begin n_fail++; $display("FAIL reset_ls cyc%0d got %0b exp 0", i, bus.L_S); end
    end
    n_tests++;
    if ({bus.Wt_addr, bus.Wt_data, bus.valid_out, bus.fwd_en, bus.load_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_fields got addr=%0d data=%h v=%0b fwd=%0b err=%0b exp all 0",
               bus.Wt_addr, bus.Wt_data, bus.valid_out, bus.fwd_en, bus.load_err);
    end
    n_tests++;
    if (bus.pc4_out !== 32'h4) begin n_fail++; $display("FAIL reset_pc4 got %h exp 00000004", bus.pc4_out); end
    rst = 0; bus.flush = 0; bus.en = 1;
  endtask

  task automatic test_alu();
    random_inputs();
    set_op(5, 0, 0, 0);
    bus.alu_in = 32'h1234_5678;
    tick();
    n_tests++;
    if ({bus.Wt_addr, bus.Wt_data, bus.L_S, bus.fwd_en} !== {5'd5, 32'h1234_5678, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL alu_write got addr=%0d data=%h ls=%0b fwd=%0b exp 5 12345678 1 1",
               bus.Wt_addr, bus.Wt_data, bus.L_S, bus.fwd_en);
    end
  endtask

  task automatic test_load_sweep();
    int        f3s  [5] = '{0, 4, 1, 5, 2};
    int        offs [5] = '{3, 3, 2, 0, 0};
    bit [31:0] exps [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01};
    for (int i = 0; i < 5; i++) begin
      random_inputs();
      set_op(9, 1, f3s[i], offs[i]);
      bus.mem_rdata_in = 32'h80FF_7F01;
      tick();
      n_tests++;
      if (bus.Wt_data !== exps[i] || bus.L_S !== 1'b1 || bus.load_err !== 1'b0) begin
        n_fail++;
        $display("FAIL load_sweep%0d got data=%h ls=%0b err=%0b exp %h 1 0",
                 i, bus.Wt_data, bus.L_S, bus.load_err, exps[i]);
      end
    end
  endtask

  task automatic test_load_err();
    int f3s  [3] = '{1, 2, 7};
    int offs [3] = '{1, 2, 0};
    for (int i = 0; i < 3; i++) begin
      random_inputs();
      set_op(11, 1, f3s[i], offs[i]);
      tick();
      n_tests++;
      if ({bus.load_err, bus.L_S, bus.Wt_data} !== {1'b1, 1'b0, 32'd0}) begin
        n_fail++;
        $display("FAIL load_err%0d got err=%0b ls=%0b data=%h exp 1 0 0",
                 i, bus.load_err, bus.L_S, bus.Wt_data);
      end
    end
    bus.en = 0;
    random_inputs();
    tick();
    n_tests++;
    if (bus.load_err !== 1'b1) begin n_fail++; $display("FAIL load_err_stall got %0b exp 1", bus.load_err); end
    bus.en = 1;
  endtask

  task automatic test_stall_flush();
    bit [31:0] frozen;
    random_inputs();
    set_op(7, 0, 0, 0);
    tick();
    frozen = bus.alu_in;
    bus.en = 0;
    for (int i = 0; i < 3; i++) begin
      random_inputs();
      tick();
      n_tests++;
      if ({bus.Wt_addr, bus.Wt_data, bus.L_S, bus.valid_out} !== {5'd7, frozen, 1'b1, 1'b1}) begin
        n_fail++;
        $display("FAIL stall%0d got addr=%0d data=%h ls=%0b v=%0b exp 7 %h 1 1",
                 i, bus.Wt_addr, bus.Wt_data, bus.L_S, bus.valid_out, frozen);
      end
    end
    bus.flush = 1;
    tick();
    n_tests++;
    if (bus.valid_out !== 1'b0 || bus.L_S !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_over_stall got v=%0b ls=%0b exp 0 0", bus.valid_out, bus.L_S);
    end
    bus.flush = 0; bus.en = 1;
  endtask

  task automatic test_x0();
    random_inputs();
    set_op(0, 2, 0, 0);
    bus.pc4_in = 32'h0000_0104;
    tick();
    n_tests++;
    if ({bus.L_S, bus.Wt_data, bus.fwd_en, bus.Wt_addr} !== {1'b1, 32'h104, 1'b0, 5'd0}) begin
      n_fail++;
      $display("FAIL x0_write got ls=%0b data=%h fwd=%0b addr=%0d exp 1 00000104 0 0",
               bus.L_S, bus.Wt_data, bus.fwd_en, bus.Wt_addr);
    end
  endtask

  task automatic test_reset_mid_stall();
    random_inputs();
    set_op(13, 3, 0, 0);
    tick();
    bus.en = 0; rst = 1;
    tick();
    n_tests++;
    if (bus.valid_out !== 1'b0 || bus.L_S !== 1'b0 || bus.pc4_out !== 32'h4) begin
      n_fail++;
      $display("FAIL reset_mid_stall got v=%0b ls=%0b pc4=%h exp 0 0 00000004",
               bus.valid_out, bus.L_S, bus.pc4_out);
    end
    rst = 0; bus.en = 1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      random_inputs();
      rst       = ($urandom_range(0, 31) == 0);
      bus.flush = ($urandom_range(0, 7) == 0);
      bus.en    = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) bus.wb_sel_in = 2'd1;
      tick();
      n_tests++;
      if (bus.Wt_addr !== e_addr || bus.Wt_data !== e_data || bus.L_S !== e_ls ||
          bus.valid_out !== e_valid || bus.fwd_en !== e_fwd || bus.load_err !== e_err ||
          bus.pc4_out !== e_pc4) begin
        n_fail++;
        $display("FAIL random%0d got a=%0d d=%h ls=%0b v=%0b f=%0b e=%0b p=%h exp a=%0d d=%h ls=%0b v=%0b f=%0b e=%0b p=%h",
                 i, bus.Wt_addr, bus.Wt_data, bus.L_S, bus.valid_out, bus.fwd_en, bus.load_err,
                 bus.pc4_out, e_addr, e_data, e_ls, e_valid, e_fwd, e_err, e_pc4);
      end
    end
    rst = 0; bus.flush = 0; bus.en = 1;
  endtask

  initial begin
    rst = 1; bus.en = 0; bus.flush = 0;
    random_inputs();
    test_reset();
    test_alu();
    test_load_sweep();
    test_load_err();
    test_stall_flush();
    test_x0();
    test_reset_mid_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
